activation_requant_layer: RTL

- Sits directly downstream of a dense layer and upstream of the next one.
- Takes the 4*latime-bit signed neuron accumulators, then applies optional ReLU, rounding right-shift requantization and saturation.
- Produces the 2*latime-bit signed vector that the next dense layer consumes as its input.
- Processes one element per clock with a small FSM and raises a sticky completion flag, so the next layer can chain off it.

---
 rtl/activation_requant_layer_pkg.sv | 16 +
 rtl/activation_requant_layer_if.sv | 24 ++
 rtl/activation_requant_layer_requant_unit.sv | 41 ++++
 rtl/activation_requant_layer.sv | 90 +++++++++
 4 files changed

// File: rtl/activation_requant_layer_pkg.sv
// Shared layer definitions: element widths, saturation limits and the layer FSM state type.
// Imported by every dense/activation layer block so chained layers agree on widths.
package nn_pkg;
    localparam int LATIME = 8;
    localparam int ACC_W  = 4 * LATIME;
    localparam int ACT_W  = 2 * LATIME;

    localparam logic signed [ACT_W-1:0] ACT_MAX = {1'b0, {(ACT_W-1){1'b1}}};
    localparam logic signed [ACT_W-1:0] ACT_MIN = {1'b1, {(ACT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } layer_state_t;
endpackage

// File: rtl/activation_requant_layer_if.sv
// Vector bus between a dense layer (master) and the activation/requant layer (slave).
// Carries the start level, the accumulator vector and the requantized result vector.
interface activation_requant_layer_if
    import nn_pkg::*;
#(
    parameter int numar_neuroni = 32,
    parameter int latime        = LATIME
);
    logic                       enable;
    logic signed [4*latime-1:0] date_intrare [0:numar_neuroni-1];
    logic signed [2*latime-1:0] date_iesire  [0:numar_neuroni-1];
    logic                       saturat;
    logic                       activare_terminata;

    modport master (
        output enable, date_intrare,
        input  date_iesire, saturat, activare_terminata
    );

    modport slave (
        input  enable, date_intrare,
        output date_iesire, saturat, activare_terminata
    );
endinterface

// File: rtl/activation_requant_layer_requant_unit.sv
// Combinational ReLU, rounding arithmetic right shift and saturation of one accumulator.
// One extra bit of headroom keeps the rounding add from wrapping at the positive extreme.
module requant_unit
    import nn_pkg::*;
#(
    parameter int latime = LATIME,
    parameter int SHIFT  = 8,
    parameter int RELU   = 1,
    parameter int ROUND  = 1
) (
    input  logic signed [4*latime-1:0] acc,
    output logic signed [2*latime-1:0] act,
    output logic                       sat
);
    localparam int ACC_WL = 4 * latime;
    localparam int ACT_WL = 2 * latime;
    localparam int W      = ACC_WL + 1;

    localparam logic signed [W-1:0] RND = (ROUND != 0) ? (W'(1) << (SHIFT - 1)) : '0;
    localparam logic signed [W-1:0] HI  = {{(W-ACT_WL+1){1'b0}}, {(ACT_WL-1){1'b1}}};
    localparam logic signed [W-1:0] LO  = {{(W-ACT_WL+1){1'b1}}, {(ACT_WL-1){1'b0}}};

    logic signed [W-1:0] v;

    always_comb begin
        v = {acc[ACC_WL-1], acc};
        if ((RELU != 0) && (v < 0)) begin
            v = '0;
        end
        v = (v + RND) >>> SHIFT;
        sat = 1'b0;
        act = v[ACT_WL-1:0];
        if (v > HI) begin
            act = HI[ACT_WL-1:0];
            sat = 1'b1;
        end else if (v < LO) begin
            act = LO[ACT_WL-1:0];
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/activation_requant_layer.sv
// Walks the accumulator vector one element per clock through requant_unit into a register file.
// Start is the level of enable in IDLE; DONE is sticky until reset and ignores enable.
module activation_requant_layer
    import nn_pkg::*;
#(
    parameter int numar_neuroni = 32,
    parameter int latime        = LATIME,
    parameter int SHIFT         = 8,
    parameter int RELU          = 1,
    parameter int ROUND         = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    activation_requant_layer_if.slave   bus
);
    localparam int ACT_WL = 2 * latime;
    localparam int IDX_W  = (numar_neuroni > 1) ? $clog2(numar_neuroni) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(numar_neuroni - 1);

    layer_state_t             state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACT_WL-1:0] dout_q [0:numar_neuroni-1];
    logic signed [ACT_WL-1:0] dout_d [0:numar_neuroni-1];
    logic                     sat_q, sat_d;
    logic                     done_q, done_d;

    logic signed [ACT_WL-1:0] elem_act;
    logic                     elem_sat;

    requant_unit #(
        .latime (latime),
        .SHIFT  (SHIFT),
        .RELU   (RELU),
        .ROUND  (ROUND)
    ) u_requant (
        .acc (bus.date_intrare[idx_q]),
        .act (elem_act),
        .sat (elem_sat)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dout_d  = dout_q;
        sat_d   = sat_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                dout_d[idx_q] = elem_act;
                sat_d         = sat_q | elem_sat;
                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: done_d = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < numar_neuroni; i++) begin
                dout_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.date_iesire        = dout_q;
    assign bus.saturat            = sat_q;
    assign bus.activare_terminata = done_q;
endmodule
